// File: rtl/look_ahead_carry_generator_16_bit_pkg.sv
`default_nettype none
// ============================================================================
// look_ahead_carry_generator_16_bit_pkg
// Shared widths and result type for the 16-bit registered lookahead adder.
// Revision: 1.0
// ============================================================================
package look_ahead_carry_generator_16_bit_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int GROUP_WIDTH = 4;
  localparam int NUM_GROUPS  = 4;

  typedef struct packed {
    logic                   carry;
    logic [ADDER_WIDTH-1:0] sum;
  } add_result_t;

endpackage : look_ahead_carry_generator_16_bit_pkg
`default_nettype wire

// File: rtl/look_ahead_carry_generator_16_bit_lcu.sv
`default_nettype none
// ============================================================================
// lookahead_carry_unit_4_bit
// Flattened 4-bit carry-lookahead unit; reused for bit groups and for groups.
// Revision: 1.0
// ============================================================================
module lookahead_carry_unit_4_bit
  import look_ahead_carry_generator_16_bit_pkg::*;
(
  input  logic [GROUP_WIDTH-1:0] P,
  input  logic [GROUP_WIDTH-1:0] G,
  input  logic                   Cin,
  output logic [GROUP_WIDTH-1:1] C,
  output logic                   Cout,
  output logic                   PG,
  output logic                   GG
);

  // Every carry is a two-level sum of products of P/G/Cin, never a ripple.
  assign C[1] = G[0]
              | (P[0] & Cin);
  assign C[2] = G[1]
              | (P[1] & G[0])
              | (P[1] & P[0] & Cin);
  assign C[3] = G[2]
              | (P[2] & G[1])
              | (P[2] & P[1] & G[0])
              | (P[2] & P[1] & P[0] & Cin);

  assign PG = &P;
  assign GG = G[3]
            | (P[3] & G[2])
            | (P[3] & P[2] & G[1])
            | (P[3] & P[2] & P[1] & G[0]);

  assign Cout = GG | (PG & Cin);

endmodule : lookahead_carry_unit_4_bit
`default_nettype wire

// File: rtl/look_ahead_carry_generator_16_bit.sv
`default_nettype none
// ============================================================================
// look_ahead_carry_generator_16_bit
// Registered 16-bit two-level carry-lookahead adder, one cycle of latency.
// Revision: 1.0
// ============================================================================
module look_ahead_carry_generator_16_bit
  import look_ahead_carry_generator_16_bit_pkg::*;
(
  input  logic                   Clock_In,
  input  logic                   Reset_In,
  input  logic [ADDER_WIDTH-1:0] Data_A_In,
  input  logic [ADDER_WIDTH-1:0] Data_B_In,
  input  logic                   Carry_In,
  output logic [ADDER_WIDTH-1:0] Sum_Out,
  output logic                   Carry_Out
);

  logic [ADDER_WIDTH-1:0] w_p;
  logic [ADDER_WIDTH-1:0] w_g;
  logic [ADDER_WIDTH-1:0] w_carry;   // carry into each bit position
  logic [NUM_GROUPS-1:0]  w_grp_pg;
  logic [NUM_GROUPS-1:0]  w_grp_gg;
  logic [NUM_GROUPS-1:0]  w_grp_cin;
  logic [NUM_GROUPS-1:0]  w_grp_cout_unused;
  logic [GROUP_WIDTH-1:1] w_l2_carry;
  logic                   w_carry_16;
  logic                   w_l2_pg_unused;
  logic                   w_l2_gg_unused;
  add_result_t            w_result_d;
  add_result_t            r_result_q;

  assign w_p = Data_A_In ^ Data_B_In;
  assign w_g = Data_A_In & Data_B_In;

  // Group carry-ins come from the level-2 unit, so groups never chain.
  assign w_grp_cin = {w_l2_carry, Carry_In};

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
    assign w_carry[g*GROUP_WIDTH] = w_grp_cin[g];

    lookahead_carry_unit_4_bit u_lcu (
      .P    (w_p[g*GROUP_WIDTH +: GROUP_WIDTH]),
      .G    (w_g[g*GROUP_WIDTH +: GROUP_WIDTH]),
      .Cin  (w_grp_cin[g]),
      .C    (w_carry[g*GROUP_WIDTH+1 +: GROUP_WIDTH-1]),
      .Cout (w_grp_cout_unused[g]),
      .PG   (w_grp_pg[g]),
      .GG   (w_grp_gg[g])
    );
  end : g_group

  lookahead_carry_unit_4_bit u_lcu_level2 (
    .P    (w_grp_pg),
    .G    (w_grp_gg),
    .Cin  (Carry_In),
    .C    (w_l2_carry),
    .Cout (w_carry_16),
    .PG   (w_l2_pg_unused),
    .GG   (w_l2_gg_unused)
  );

  always_comb begin
    w_result_d       = '0;
    w_result_d.sum   = w_p ^ w_carry;
    w_result_d.carry = w_carry_16;
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_result_q <= '0;
    end else begin
      r_result_q <= w_result_d;
    end
  end

  assign Sum_Out   = r_result_q.sum;
  assign Carry_Out = r_result_q.carry;

endmodule : look_ahead_carry_generator_16_bit
`default_nettype wire

// File: tb/tb_look_ahead_carry_generator_16_bit.sv
`default_nettype none
// ============================================================================
// tb_look_ahead_carry_generator_16_bit
// Directed-table and streaming bench for the registered lookahead adder.
// Revision: 1.0
// ============================================================================
module tb_look_ahead_carry_generator_16_bit;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;

  int n_pass;
  int n_total;

  vec_t vecs [12];

  look_ahead_carry_generator_16_bit dut (
    .Clock_In  (clk),
    .Reset_In  (rst),
    .Data_A_In (a),
    .Data_B_In (b),
    .Carry_In  (cin),
    .Sum_Out   (sum),
    .Carry_Out (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] exp_sum, input logic exp_cout);
    n_total++;
    if (sum === exp_sum && cout === exp_cout) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
               name, sum, cout, exp_sum, exp_cout);
    end
  endtask

  initial begin
    logic [16:0] ref_sum;
    logic [16:0] prev_ref;

    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[6]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
    vecs[7]  = '{16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1};
    vecs[8]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[9]  = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    vecs[10] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
    vecs[11] = '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0};

    // Asynchronous reset with nonzero operands present
    rst = 1'b0;
    a   = 16'h1234;
    b   = 16'h4321;
    cin = 1'b1;
    #2 rst = 1'b1;
    #1 check("reset_immediate", 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("reset_held_1", 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("reset_held_2", 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release", 16'h5556, 1'b0);

    // Directed table, one vector per cycle
    for (int i = 0; i < 12; i++) begin
      a   = vecs[i].a;
      b   = vecs[i].b;
      cin = vecs[i].cin;
      @(posedge clk); #1;
      check($sformatf("vec_%0d", i), vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Inputs changing between edges must not reach the outputs
    a   = 16'h0001;
    b   = 16'h0002;
    cin = 1'b0;
    #2 check("no_comb_path", 16'hFFFF, 1'b0);
    @(posedge clk); #1;
    check("after_comb_edge", 16'h0003, 1'b0);

    // Back-to-back random stream
    for (int i = 0; i < 20; i++) begin
      a       = 16'($urandom);
      b       = 16'($urandom);
      cin     = 1'($urandom);
      ref_sum = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
      @(posedge clk); #1;
      check($sformatf("stream_%0d", i), ref_sum[15:0], ref_sum[16]);
    end

    // Mid-stream reset pulse shorter than a cycle
    a        = 16'hC000;
    b        = 16'h4001;
    cin      = 1'b1;
    prev_ref = 17'h10002;
    @(posedge clk); #1;
    check("pre_reset_result", prev_ref[15:0], prev_ref[16]);
    a   = 16'h2222;
    b   = 16'h1111;
    cin = 1'b0;
    #2 rst = 1'b1;
    #1 check("midstream_reset_clear", 16'h0000, 1'b0);
    #1 rst = 1'b0;
    #1 check("midstream_reset_hold", 16'h0000, 1'b0);
    @(posedge clk); #1;
    check("midstream_resume", 16'h3333, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_look_ahead_carry_generator_16_bit
`default_nettype wire
